// File: rtl/machine_p_if.sv
// rtl/machine_p_if.sv - serial pattern detector data/status bundle
interface machine_p_if #(
  parameter int SW    = 2,
  parameter int CNT_W = 4
);
  logic             x;
  logic             EN;
  logic             CLR;
  logic             F;
  logic [SW-1:0]    S;
  logic [CNT_W-1:0] COUNT;

  modport master (output x, EN, CLR, input F, S, COUNT);
  modport slave  (input x, EN, CLR, output F, S, COUNT);
endinterface

// File: rtl/machine_p.sv
// rtl/machine_p.sv - KMP serial pattern detector with Moore match flag and saturating count
module machine_p #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  machine_p_if.slave  bus
);
  localparam int               SW      = $clog2(N + 1);
  localparam int               NS      = 2 ** SW;
  localparam logic [SW-1:0]    S_IDLE  = '0;
  localparam logic [SW-1:0]    S_FULL  = SW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Longest suffix of (first k pattern bits, then b) that is also a pattern prefix.
  // Leaving S=N in non-overlap mode starts from an empty history instead.
  function automatic int next_k(input int k, input bit b);
    int len;
    int hit;
    int idx;
    bit ok;
    bit c;
    len = (k == N && OVERLAP == 1'b0) ? 0 : k;
    hit = 0;
    for (int l = 1; l <= N; l++) begin
      if (l <= len + 1) begin
        ok = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j < l) begin
            idx = len + 1 - l + j;
            if (idx == len) c = b;
            else            c = PATTERN[N-1-idx];
            if (c != PATTERN[N-1-j]) ok = 1'b0;
          end
        end
        if (ok) hit = l;
      end
    end
    return hit;
  endfunction

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_tbl
      if (g <= N) begin : g_valid
        localparam logic [SW-1:0] K0 = SW'(next_k(g, 1'b0));
        localparam logic [SW-1:0] K1 = SW'(next_k(g, 1'b1));
        assign nxt0[g] = K0;
        assign nxt1[g] = K1;
      end else begin : g_pad
        assign nxt0[g] = S_IDLE;
        assign nxt1[g] = S_IDLE;
      end
    end
  endgenerate

  logic [SW-1:0]    s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    if (bus.EN) begin
      s_d = bus.x ? nxt1[s_q] : nxt0[s_q];
      if (s_d == S_FULL && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    // Clear wins over a same-edge match and ignores EN.
    if (bus.CLR) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s_q   <= S_IDLE;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.S     = s_q;
  assign bus.F     = (s_q == S_FULL);
  assign bus.COUNT = cnt_q;
endmodule

// File: tb/tb_machine_p.sv
// tb/tb_machine_p.sv - scoreboard bench for machine_p across four parameter sets
module tb_machine_p;
  logic CLK;
  logic RESET_N;

  machine_p_if #(.SW(2), .CNT_W(4)) if0 ();
  machine_p_if #(.SW(2), .CNT_W(4)) if1 ();
  machine_p_if #(.SW(2), .CNT_W(4)) if2 ();
  machine_p_if #(.SW(2), .CNT_W(2)) if3 ();

  machine_p #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(4))
    u0 (.CLK(CLK), .RESET_N(RESET_N), .bus(if0.slave));
  machine_p #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(4))
    u1 (.CLK(CLK), .RESET_N(RESET_N), .bus(if1.slave));
  machine_p #(.N(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(4))
    u2 (.CLK(CLK), .RESET_N(RESET_N), .bus(if2.slave));
  machine_p #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2))
    u3 (.CLK(CLK), .RESET_N(RESET_N), .bus(if3.slave));

  typedef struct {
    int    id;
    int    s;
    int    f;
    int    c;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic read_dut(input int id, output int s, output int f, output int c);
    case (id)
      0:       begin s = int'(if0.S); f = int'(if0.F); c = int'(if0.COUNT); end
      1:       begin s = int'(if1.S); f = int'(if1.F); c = int'(if1.COUNT); end
      2:       begin s = int'(if2.S); f = int'(if2.F); c = int'(if2.COUNT); end
      default: begin s = int'(if3.S); f = int'(if3.F); c = int'(if3.COUNT); end
    endcase
  endtask

  task automatic idle_all();
    if0.x = 1'b0; if0.EN = 1'b0; if0.CLR = 1'b0;
    if1.x = 1'b0; if1.EN = 1'b0; if1.CLR = 1'b0;
    if2.x = 1'b0; if2.EN = 1'b0; if2.CLR = 1'b0;
    if3.x = 1'b0; if3.EN = 1'b0; if3.CLR = 1'b0;
  endtask

  task automatic drive(input int id, input logic xv, input logic en, input logic clr);
    idle_all();
    case (id)
      0:       begin if0.x = xv; if0.EN = en; if0.CLR = clr; end
      1:       begin if1.x = xv; if1.EN = en; if1.CLR = clr; end
      2:       begin if2.x = xv; if2.EN = en; if2.CLR = clr; end
      default: begin if3.x = xv; if3.EN = en; if3.CLR = clr; end
    endcase
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input string tag, input int id, input logic xv, input logic en,
                      input logic clr, input int es, input int ef, input int ec);
    exp_t e;
    @(negedge CLK);
    drive(id, xv, en, clr);
    e.id = id; e.s = es; e.f = ef; e.c = ec; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag, input int id);
    int s, f, c;
    read_dut(id, s, f, c);
    chk({tag, ".S"}, s, 0);
    chk({tag, ".F"}, f, 0);
    chk({tag, ".COUNT"}, c, 0);
  endtask

  initial begin : monitor
    exp_t e;
    int s, f, c;
    forever begin
      @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        read_dut(e.id, s, f, c);
        chk({e.tag, ".S"}, s, e.s);
        chk({e.tag, ".F"}, f, e.f);
        chk({e.tag, ".COUNT"}, c, e.c);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int xs [9];
    int ss [9];
    int fs [9];
    int cs [9];
    total = 0;
    bad   = 0;
    idle_all();
    RESET_N = 1'b0;
    #3;
    for (int d = 0; d < 4; d++) chk_zero($sformatf("reset_d%0d", d), d);
    @(negedge CLK);
    RESET_N = 1'b1;

    // 10101, overlapping vs non-overlapping
    xs = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    ss = '{1, 2, 3, 2, 3, 0, 0, 0, 0};
    fs = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    cs = '{0, 0, 1, 1, 2, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++)
      step($sformatf("ovl_e%0d", i + 1), 0, xs[i][0], 1'b1, 1'b0, ss[i], fs[i], cs[i]);
    ss = '{1, 2, 3, 0, 1, 0, 0, 0, 0};
    fs = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    cs = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++)
      step($sformatf("novl_e%0d", i + 1), 1, xs[i][0], 1'b1, 1'b0, ss[i], fs[i], cs[i]);

    // Clear with EN=0 zeroes COUNT but leaves S=3/F=1
    step("clr_noen", 0, 1'b0, 1'b0, 1'b1, 3, 1, 0);

    // Pattern 110 with KMP fallback 2 -> 2 on the third 1
    xs = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    ss = '{1, 2, 2, 3, 0, 0, 0, 0, 0};
    fs = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    cs = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++)
      step($sformatf("p110_e%0d", i + 1), 2, xs[i][0], 1'b1, 1'b0, ss[i], fs[i], cs[i]);

    // Saturation at 3 with CNT_W=2, then clear beats a 5th match
    xs = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    ss = '{1, 2, 3, 2, 3, 2, 3, 2, 3};
    fs = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
    cs = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
    for (int i = 0; i < 9; i++)
      step($sformatf("sat_e%0d", i + 1), 3, xs[i][0], 1'b1, 1'b0, ss[i], fs[i], cs[i]);
    step("sat_e10", 3, 1'b0, 1'b1, 1'b0, 2, 0, 3);
    step("sat_clr", 3, 1'b1, 1'b1, 1'b1, 3, 1, 0);

    // Fresh history, then EN=0 hold with x toggling
    @(negedge CLK);
    idle_all();
    RESET_N = 1'b0;
    #2;
    chk_zero("rst2_d0", 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step("hold_e1", 0, 1'b1, 1'b1, 1'b0, 1, 0, 0);
    step("hold_e2", 0, 1'b0, 1'b1, 1'b0, 2, 0, 0);
    step("hold_h1", 0, 1'b1, 1'b0, 1'b0, 2, 0, 0);
    step("hold_h2", 0, 1'b0, 1'b0, 1'b0, 2, 0, 0);
    step("hold_h3", 0, 1'b1, 1'b0, 1'b0, 2, 0, 0);
    step("hold_e3", 0, 1'b1, 1'b1, 1'b0, 3, 1, 1);
    step("pre_rst", 0, 1'b0, 1'b1, 1'b0, 2, 0, 1);

    // Async reset mid-cycle at S=2/COUNT=1, held across an edge that would complete the match
    @(posedge CLK);
    #3;
    idle_all();
    if0.x = 1'b1;
    if0.EN = 1'b1;
    RESET_N = 1'b0;
    #1;
    chk_zero("async_rst", 0);
    @(posedge CLK);
    #1;
    chk_zero("rst_held", 0);
    @(negedge CLK);
    idle_all();
    RESET_N = 1'b1;
    step("post_rst_e1", 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    step("post_rst_e2", 0, 1'b1, 1'b1, 1'b0, 1, 0, 0);

    @(negedge CLK);
    idle_all();
    repeat (2) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/machine_p.md
MACHINE_P -- requirements
Module: machine_p

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the clock port SHALL be CLK and the reset port SHALL be RESET_N.
REQ-002 Parameter N, default 3, SHALL set the pattern length, legal range 2..8.
REQ-003 Parameter PATTERN, default 3'b101, width N, SHALL hold the target sequence; PATTERN[N-1] is the first bit expected.
REQ-004 Parameter OVERLAP, default 1, SHALL select detection mode: 1 = overlapping matches, 0 = non-overlapping (restart after match).
REQ-005 Parameter CNT_W, default 4, SHALL set the match-counter width, legal range 1..16.
REQ-006 The block SHALL provide these ports (name, direction, width, meaning):
- CLK      input   1           rising-edge clock
- RESET_N  input   1           asynchronous active-low reset
- x        input   1           serial data bit, sampled on the CLK rising edge
- EN       input   1           advance enable; 0 = hold all state
- CLR      input   1           synchronous clear of COUNT only
- F        output  1           Moore match flag
- S        output  SW          current state, SW = clog2(N+1)
- COUNT    output  CNT_W       saturating match count

Function
REQ-007 S = k SHALL mean k is the length of the longest suffix of the bit history (since reset or restart) that equals the first k bits of PATTERN, with 0 <= k <= N.
REQ-008 On a CLK rising edge with EN=1, S SHALL update to the k obtained by appending x to the history.
- Fallback on mismatch SHALL follow the longest-proper-prefix-suffix rule (KMP).
- The rule SHALL NOT simply return to 0.
REQ-009 With OVERLAP=1, the transition out of S=N SHALL treat the matched N bits as history.
REQ-010 With OVERLAP=0, the transition out of S=N SHALL treat the history as empty: the next S is 1 if x equals PATTERN[N-1], otherwise 0.
REQ-011 With EN=0, S, F and COUNT SHALL hold; x SHALL be ignored.
REQ-012 F SHALL be 1 exactly while S==N (Moore, registered state, no combinational path from x).
REQ-013 COUNT SHALL increment by 1 on each edge where S enters N, including re-entry N->N in OVERLAP=1.
REQ-014 COUNT SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 CLR=1 at an edge SHALL set COUNT to 0.
- CLR SHALL take priority over a simultaneous increment.
- CLR SHALL NOT affect S or F.
- CLR SHALL act regardless of EN.
REQ-016 The next-state function SHALL be derived from the parameters at elaboration time; no runtime pattern loading.
REQ-017 Latency SHALL be as follows:
- F rises on the same edge that samples the last pattern bit, visible one clock after that bit is presented.
- F stays high for one clock per match unless re-matched.

Reset
REQ-018 RESET_N=0 SHALL immediately, without waiting for CLK, force S=0, F=0 and COUNT=0.
REQ-019 While RESET_N=0, all state SHALL hold at reset values regardless of CLK, x, EN and CLR.
REQ-020 After RESET_N deasserts, the first rising edge SHALL process x from an empty history.
REQ-021 Reset asserted mid-pattern SHALL discard partial progress; no match may be credited to bits received before reset.

Verification
REQ-022 Default parameters (N=3, PATTERN=101, OVERLAP=1), EN=1, x=1,0,1,0,1 -> S=1,2,3,2,3; F high after edges 3 and 5; COUNT=2.
REQ-023 Same stimulus with OVERLAP=0 -> S=1,2,3,0,1; F high only after edge 3; COUNT=1.
REQ-024 PATTERN=110, x=1,1,1,0 -> S=1,2,2,3; F high after edge 4 only; COUNT=1.
REQ-025 Default parameters, x=1,0 then EN=0 for 3 edges with x toggling, then EN=1 and x=1 -> S holds 2 during EN=0, then S=3; COUNT=1.
REQ-026 CNT_W=2, OVERLAP=1, x=1,0,1,0,1,0,1,0,1 (4 matches) -> COUNT=3 saturated; CLR pulsed together with a 5th match -> COUNT=0.
REQ-027 Default parameters, reach S=2 and COUNT=1, assert RESET_N=0 between clock edges -> S=0, F=0, COUNT=0 before the next edge; after release, x=0,1 -> S=0,1.
